// File: rtl/sqrt_pkg.sv
// Shared types for the square-root scheduler: FSM states, default widths and the
// remainder working word.
package sqrt_pkg;

    localparam int N_BITS_DEF = 32;
    localparam int ROOT_W     = N_BITS_DEF / 2;
    localparam int ITER_CNT_W = $clog2(ROOT_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef logic [ROOT_W+1:0]     rem_t;
    typedef logic [N_BITS_DEF-1:0] rad_t;

    function automatic int root_w_of(input int n_bits);
        return n_bits / 2;
    endfunction

endpackage

// File: rtl/sqrt_iter_core.sv
// Restoring digit-by-digit square root: two radicand bits consumed per step.
// root_o/rem_o show the values after the current step, so done_o can be captured directly.
module sqrt_iter_core
    import sqrt_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [N_BITS-1:0]   radicand_i,
    input  logic                step_i,
    output logic                done_o,
    output logic [N_BITS/2-1:0] root_o,
    output logic [N_BITS/2+1:0] rem_o
);

    localparam int RT_W  = root_w_of(N_BITS);
    localparam int REM_W = RT_W + 2;
    localparam int CNT_W = (RT_W > 1) ? $clog2(RT_W) : 1;

    logic [N_BITS-1:0] rad_q;
    logic [N_BITS-1:0] rad_d;
    logic [REM_W-1:0]  rem_q;
    logic [REM_W-1:0]  rem_d;
    logic [RT_W-1:0]   root_q;
    logic [RT_W-1:0]   root_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [REM_W+1:0]  trial;
    logic              trial_ge;

    // Both top bits of the trial are set whenever the subtraction goes negative.
    always_comb begin
        trial    = {rem_q, rad_q[N_BITS-1 -: 2]} - {2'b00, root_q, 2'b01};
        trial_ge = ~|trial[REM_W+1:REM_W];
        rad_d    = {rad_q[N_BITS-3:0], 2'b00};
        rem_d    = trial_ge ? trial[REM_W-1:0] : {rem_q[REM_W-3:0], rad_q[N_BITS-1 -: 2]};
        root_d   = {root_q[RT_W-2:0], trial_ge};
    end

    assign done_o = step_i && (cnt_q == '0);
    assign root_o = root_d;
    assign rem_o  = rem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            rad_q  <= radicand_i;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CNT_W'(RT_W - 1);
        end else if (step_i) begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Round-robin sharing of one iterative square-root core between N_REQ requesters.
// Define SQRT_ROUND_EN to round the root to nearest instead of truncating.
//   state | meaning
//   IDLE  | arbitrate; req_ready to the winner, radicand/ID latched on transfer
//   CALC  | one digit step per cycle, N_BITS/2 cycles
//   DONE  | one-cycle resp_valid strobe
module sqrt_share_ctrl
    import sqrt_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*N_BITS-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    resp_valid_o,
    output logic [ID_W-1:0]         resp_id_o,
    output logic [N_BITS/2-1:0]     resp_root_o,
    output logic                    resp_neg_err_o,
    output logic                    busy_o
);

    localparam int RT_W  = root_w_of(N_BITS);
    localparam int REM_W = RT_W + 2;

    state_e            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic              resp_valid_q;
    logic [ID_W-1:0]   resp_id_q;
    logic [RT_W-1:0]   resp_root_q;
    logic              resp_neg_q;

    logic              any_win;
    logic [ID_W-1:0]   win_id;
    logic [ID_W:0]     rr_sum;
    logic [ID_W-1:0]   rr_idx;
    logic [N_BITS-1:0] win_data;
    logic              win_neg;
    logic              accept;
    logic [ID_W-1:0]   ptr_d;

    logic              core_done;
    logic [RT_W-1:0]   core_root;
    logic [REM_W-1:0]  core_rem;
    logic [RT_W-1:0]   root_fin;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        any_win = 1'b0;
        win_id  = '0;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (rr_sum >= (ID_W+1)'(N_REQ)) begin
                rr_sum = rr_sum - (ID_W+1)'(N_REQ);
            end
            rr_idx = rr_sum[ID_W-1:0];
            if (!any_win && req_valid_i[rr_idx]) begin
                any_win = 1'b1;
                win_id  = rr_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_id == ID_W'(k)) begin
                win_data = req_data_i[k*N_BITS +: N_BITS];
            end
        end
    end

    assign win_neg     = win_data[N_BITS-1];
    assign accept      = (state_q == IDLE) && any_win;
    assign ptr_d       = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
    assign req_ready_o = accept ? (N_REQ'(1) << win_id) : '0;

    sqrt_iter_core #(
        .N_BITS (N_BITS)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && !win_neg),
        .radicand_i (win_data),
        .step_i     (state_q == CALC),
        .done_o     (core_done),
        .root_o     (core_root),
        .rem_o      (core_rem)
    );

`ifdef SQRT_ROUND_EN
    // Remainder above the floor root means the true root is at least root + 0.5.
    always_comb begin
        root_fin = core_root;
        if (({2'b00, core_root} < core_rem) && (core_root != '1)) begin
            root_fin = core_root + RT_W'(1);
        end
    end
`else
    logic rem_unused;
    assign rem_unused = ^core_rem;
    assign root_fin   = core_root;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_root_q  <= '0;
            resp_neg_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ptr_q <= ptr_d;
                        id_q  <= win_id;
                        if (win_neg) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_id_q    <= win_id;
                            resp_root_q  <= '0;
                            resp_neg_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (core_done) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_root_q  <= root_fin;
                        resp_neg_q   <= 1'b0;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign resp_id_o      = resp_id_q;
    assign resp_root_o    = resp_root_q;
    assign resp_neg_err_o = resp_neg_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Bench for sqrt_share_ctrl: directed cases plus random multi-requester traffic against
// a cycle-level reference model (round-robin pick, fixed latencies, integer sqrt).
`timescale 1ns/1ps
module tb_sqrt_share_ctrl;

    localparam int N  = 4;
    localparam int NB = 32;
    localparam int RW = NB / 2;
    localparam int IW = 2;
    localparam int LAT_OK  = RW + 1;
    localparam int LAT_NEG = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*NB-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [IW-1:0]   resp_id;
    logic [RW-1:0]   resp_root;
    logic            resp_neg_err;
    logic            busy;

    sqrt_share_ctrl #(
        .N_BITS (NB),
        .N_REQ  (N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .resp_valid_o   (resp_valid),
        .resp_id_o      (resp_id),
        .resp_root_o    (resp_root),
        .resp_neg_err_o (resp_neg_err),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint ref_root(input longint x);
        longint r;
        r = longint'($sqrt(real'(x)));
        while (r > 0 && r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
`ifdef SQRT_ROUND_EN
        if (x - r * r > r) r++;
        if (r > (longint'(1) << RW) - 1) r = (longint'(1) << RW) - 1;
`endif
        return r;
    endfunction

    typedef struct {
        int     due;
        int     id;
        longint root;
        bit     neg;
    } exp_t;

    typedef struct {
        int id;
        int root;
        bit neg;
    } rsp_t;

    exp_t   exp_q[$];
    rsp_t   rsp_log[$];
    int     order_q[$];

    int     m_ptr = 0, m_free = 0, m_acc = 0;
    int     hold_id = 0;
    longint hold_root = 0;
    bit     hold_neg = 0;
    logic [N-1:0] acc_seen = '0;
    int     resp_cnt = 0;
    int     last_acc_cyc = 0, last_resp_cyc = 0;
    int     last_id = 0, last_root = 0;
    bit     last_neg = 0;

    int          mon_win, mon_idx, mon_exp_ready;
    bit          mon_rv;
    logic [NB-1:0] mon_d;
    longint      mon_x;
    exp_t        mon_e;
    rsp_t        mon_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_resp_valid", resp_valid, 0);
            check_eq("rst_resp_id", resp_id, 0);
            check_eq("rst_resp_root", resp_root, 0);
            check_eq("rst_resp_neg_err", resp_neg_err, 0);
            check_eq("rst_busy", busy, 0);
            exp_q.delete();
            m_ptr = 0; m_free = 0; m_acc = 0;
            hold_id = 0; hold_root = 0; hold_neg = 0;
            acc_seen = '0;
        end else begin
            mon_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check_eq("resp_valid", resp_valid, mon_rv);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                hold_id = mon_e.id; hold_root = mon_e.root; hold_neg = mon_e.neg;
            end
            check_eq("resp_id", resp_id, hold_id);
            check_eq("resp_root", resp_root, hold_root);
            check_eq("resp_neg_err", resp_neg_err, hold_neg);
            check_eq("busy", busy, (cyc > m_acc) && (cyc < m_free));

            mon_win = -1;
            if (cyc >= m_free) begin
                for (int k = 0; k < N; k++) begin
                    mon_idx = (m_ptr + k) % N;
                    if (mon_win < 0 && req_valid[mon_idx]) mon_win = mon_idx;
                end
            end
            mon_exp_ready = (mon_win >= 0) ? (1 << mon_win) : 0;
            check_eq("req_ready", req_ready, mon_exp_ready);

            if (mon_win >= 0) begin
                mon_d = req_data[mon_win*NB +: NB];
                mon_x = mon_d[NB-1] ? longint'(mon_d) - (longint'(1) << NB) : longint'(mon_d);
                mon_e.id   = mon_win;
                mon_e.neg  = (mon_x < 0);
                mon_e.root = (mon_x < 0) ? 0 : ref_root(mon_x);
                mon_e.due  = cyc + ((mon_x < 0) ? LAT_NEG : LAT_OK);
                exp_q.push_back(mon_e);
                m_ptr  = (mon_win + 1) % N;
                m_acc  = cyc;
                m_free = cyc + ((mon_x < 0) ? LAT_NEG + 1 : LAT_OK + 1);
            end

            acc_seen = req_valid & req_ready;
            for (int k = 0; k < N; k++) begin
                if (acc_seen[k]) begin
                    order_q.push_back(k);
                    last_acc_cyc = cyc;
                end
            end
            if (resp_valid) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                last_id = resp_id; last_root = resp_root; last_neg = resp_neg_err;
                mon_r.id = resp_id; mon_r.root = resp_root; mon_r.neg = resp_neg_err;
                rsp_log.push_back(mon_r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [NB-1:0] val);
        int t;
        int c0;
        c0 = resp_cnt;
        req_data[id*NB +: NB] = val;
        req_valid[id] = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!acc_seen[id] && t < 200);
        check_eq("accept_wait", t < 200, 1);
        req_valid[id] = 1'b0;
        t = 0;
        while (resp_cnt == c0 && t < 40) begin tick(); t++; end
        check_eq("resp_wait", resp_cnt != c0, 1);
    endtask

    task automatic all_four();
        int t;
        int c0;
        order_q.delete();
        rsp_log.delete();
        c0 = resp_cnt;
        for (int i = 0; i < N; i++) req_data[i*NB +: NB] = NB'((i + 4) * (i + 4));
        req_valid = '1;
        t = 0;
        while ((resp_cnt - c0 < N) && t < 200) begin
            tick();
            req_valid = req_valid & ~acc_seen;
            t++;
        end
        req_valid = '0;
        check_eq("all4_n_accept", order_q.size(), N);
        check_eq("all4_n_resp", rsp_log.size(), N);
        for (int k = 0; k < N && k < order_q.size(); k++) check_eq("all4_order", order_q[k], k);
        for (int k = 0; k < N && k < rsp_log.size(); k++) begin
            check_eq("all4_resp_id", rsp_log[k].id, k);
            check_eq("all4_resp_root", rsp_log[k].root, k + 4);
        end
        tick();
    endtask

    function automatic logic [NB-1:0] rand_rad();
        int unsigned r;
        case ($urandom_range(0, 5))
            0: return NB'($urandom);
            1: return NB'($urandom_range(0, 300));
            2: return 32'h7FFF_FFFF;
            3: return NB'($urandom) & 32'h7FFF_FFFF;
            4: begin r = $urandom_range(0, 46340); return NB'(r * r); end
            default: begin r = $urandom_range(1, 46340); return NB'(r * r + r); end
        endcase
    endfunction

    logic [NB-1:0] edge_val [4];
    int            edge_exp [4];
    int            c_rst;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        all_four();
        all_four();

        send(0, 32'd100);
        check_eq("r100_id", last_id, 0);
        check_eq("r100_root", last_root, 10);
        check_eq("r100_neg", last_neg, 0);
        check_eq("r100_latency", last_resp_cyc - last_acc_cyc, LAT_OK);

        edge_val[0] = 32'd0; edge_val[1] = 32'd1; edge_val[2] = 32'd2; edge_val[3] = 32'h7FFF_FFFF;
`ifdef SQRT_ROUND_EN
        edge_exp[0] = 0; edge_exp[1] = 1; edge_exp[2] = 1; edge_exp[3] = 46341;
`else
        edge_exp[0] = 0; edge_exp[1] = 1; edge_exp[2] = 1; edge_exp[3] = 46340;
`endif
        for (int k = 0; k < 4; k++) begin
            send(2, edge_val[k]);
            check_eq("edge_id", last_id, 2);
            check_eq("edge_root", last_root, edge_exp[k]);
        end

        send(1, 32'hFFFF_FFFC);
        check_eq("neg_id", last_id, 1);
        check_eq("neg_root", last_root, 0);
        check_eq("neg_err", last_neg, 1);
        check_eq("neg_latency", last_resp_cyc - last_acc_cyc, LAT_NEG);

        // Abort an operation five cycles into the calculation.
        req_data[0 +: NB] = 32'd81;
        req_valid[0] = 1'b1;
        c_rst = 0;
        do begin tick(); c_rst++; end while (!acc_seen[0] && c_rst < 200);
        req_valid[0] = 1'b0;
        repeat (5) tick();
        c_rst = resp_cnt;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (25) tick();
        check_eq("no_resp_after_rst", resp_cnt - c_rst, 0);
        send(0, 32'd81);
        check_eq("r81_root", last_root, 9);

        send(0, 32'd3);
`ifdef SQRT_ROUND_EN
        check_eq("r3_root", last_root, 2);
`else
        check_eq("r3_root", last_root, 1);
`endif
        send(0, 32'd8);
`ifdef SQRT_ROUND_EN
        check_eq("r8_root", last_root, 3);
`else
        check_eq("r8_root", last_root, 2);
`endif

        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && acc_seen[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_data[i*NB +: NB] = rand_rad();
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 39) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        repeat (40) tick();
        check_eq("drain_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
